seq_multiplier: RTL and testbench

- Iterative shift-and-add multiplier for N-bit operands producing a full 2N-bit product.
- Each cycle forms one gated, shifted partial product of the multiplicand and accumulates it.
- Selectable unsigned or two's-complement mode.
- Sits between operand-producing logic and downstream consumers, using valid/ready handshakes on both sides.

---
 rtl/seq_multiplier.sv | 138 +++++++++++++
 tb/tb_seq_multiplier.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Iterative shift-and-add multiplier. One partial product of the
//   multiplicand, gated by one multiplier bit, is accumulated per clock, so a
//   full 2N-bit product is ready N clocks after the operands are accepted.
//   Supports unsigned and two's-complement operands.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   in_valid      operands and mode are presented
//   in_ready      block can accept operands (IDLE)
//   multiplicand  operand A, N bits
//   multiplier    operand B, N bits
//   signed_mode   1 = two's-complement, 0 = unsigned
//   out_valid     product valid and held (DONE)
//   out_ready     consumer accepts the product
//   product       2N-bit result A*B, held until the next result
//   busy          high while iterating (RUN)
module seq_multiplier #(
   parameter int N = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   input  logic           signed_mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int CNT_W = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [2*N-1:0] a_ext;     // multiplicand extended to product width
   logic [N-1:0]   b_reg;     // captured multiplier
   logic           smode;     // captured signed_mode
   logic [2*N-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic [N-1:0]   b_shift;
   logic [2*N-1:0] pp;
   logic [2*N-1:0] acc_sum;
   logic           last_step;

   // Partial product for the current step. Shifting the multiplier down and
   // taking bit 0 avoids indexing with the wider counter.
   always_comb begin
      b_shift   = b_reg >> cnt;
      pp        = b_shift[0] ? (a_ext << cnt) : '0;
      last_step = (cnt == CNT_W'(N - 1));
      // In signed mode the multiplier MSB carries weight -2^(N-1), so its
      // partial product is subtracted instead of added.
      if (last_step && smode)
         acc_sum = acc - pp;
      else
         acc_sum = acc + pp;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Datapath: operand capture, accumulation, result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_ext   <= '0;
         b_reg   <= '0;
         smode   <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (signed_mode)
                     a_ext <= {{N{multiplicand[N-1]}}, multiplicand};
                  else
                     a_ext <= {{N{1'b0}}, multiplicand};
                  b_reg <= multiplier;
                  smode <= signed_mode;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               acc <= acc_sum;
               cnt <= cnt + 1'b1;
               if (last_step)
                  product <= acc_sum;
            end
            default: begin
               // DONE: everything held; product stays until the next result
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // N = 5 instance
   logic       in_valid5, in_ready5, sm5, out_valid5, out_ready5, busy5;
   logic [4:0] a5, b5;
   logic [9:0] p5;

   // N = 8 instance
   logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int checks = 0;
   int passes = 0;

   seq_multiplier #(.N(5)) u_dut5 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid5), .in_ready(in_ready5),
      .multiplicand(a5), .multiplier(b5), .signed_mode(sm5),
      .out_valid(out_valid5), .out_ready(out_ready5),
      .product(p5), .busy(busy5)
   );

   seq_multiplier #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .multiplicand(a8), .multiplier(b8), .signed_mode(sm8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .product(p8), .busy(busy8)
   );

   // Reference: interpret operands per mode, multiply as integers, wrap to 2n bits.
   function automatic longint ref_mul(input longint a, input longint b,
                                      input bit s, input int n);
      longint av, bv;
      av = a;
      bv = b;
      if (s && a[n-1]) av = a - (longint'(1) << n);
      if (s && b[n-1]) bv = b - (longint'(1) << n);
      return (av * bv) & ((longint'(1) << (2 * n)) - 1);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid5 = 0; a5 = 0; b5 = 0; sm5 = 0; out_ready5 = 1;
      in_valid8 = 0; a8 = 0; b8 = 0; sm8 = 0; out_ready8 = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready5 !== 1'b1 || out_valid5 !== 1'b0 || busy5 !== 1'b0 || p5 !== 10'd0)
         $display("FAIL reset5: in_ready=%b out_valid=%b busy=%b product=%0d required 1 0 0 0",
                  in_ready5, out_valid5, busy5, p5);
      else passes++;
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'd0)
         $display("FAIL reset8: in_ready=%b out_valid=%b busy=%b product=%0d required 1 0 0 0",
                  in_ready8, out_valid8, busy8, p8);
      else passes++;
      #3 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // One operation on the N=5 instance with out_ready held high.
   // Called one time unit after a rising edge with the block idle.
   task automatic do_op5(input logic [4:0] a, input logic [4:0] b, input bit s,
                         input logic [9:0] exp, input string name);
      int lat;
      a5 = a; b5 = b; sm5 = s; in_valid5 = 1'b1;
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      lat = 0;
      while (out_valid5 !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("op %s: A=%0d B=%0d signed=%0b product=0x%0h latency=%0d", name, a, b, s, p5, lat);
      checks++;
      if (lat !== 5) $display("FAIL %s latency: got %0d required 5", name, lat);
      else passes++;
      checks++;
      if (p5 !== exp) $display("FAIL %s product: got 0x%0h required 0x%0h", name, p5, exp);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1)
         $display("FAIL %s return_idle: out_valid=%b in_ready=%b required 0 1",
                  name, out_valid5, in_ready5);
      else passes++;
   endtask

   task automatic test_unsigned_max();
      out_ready5 = 1'b1;
      do_op5(5'd31, 5'd31, 1'b0, 10'h3C1, "u_max");
   endtask

   task automatic test_signed();
      do_op5(5'h10, 5'h10, 1'b1, 10'h100, "s_neg16_neg16");
      do_op5(5'h10, 5'h0F, 1'b1, 10'h310, "s_neg16_15");
      do_op5(5'd7,  5'h1F, 1'b1, 10'h3F9, "s_7_neg1");
   endtask

   task automatic test_stall();
      int w;
      out_ready5 = 1'b0;
      a5 = 5'h10; b5 = 5'h1F; sm5 = 1'b0; in_valid5 = 1'b1;
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      w = 0;
      while (out_valid5 !== 1'b1 && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      $display("op stall: A=16 B=31 product=%0d", p5);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin in_valid5 = 1'b1; a5 = 5'd1; b5 = 5'd1; end
         if (i == 6) in_valid5 = 1'b0;
         checks++;
         if (p5 !== 10'd496 || out_valid5 !== 1'b1 || in_ready5 !== 1'b0)
            $display("FAIL stall_hold cycle %0d: product=%0d out_valid=%b in_ready=%b required 496 1 0",
                     i, p5, out_valid5, in_ready5);
         else passes++;
      end
      out_ready5 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1 || p5 !== 10'd496)
         $display("FAIL stall_release: out_valid=%b in_ready=%b product=%0d required 0 1 496",
                  out_valid5, in_ready5, p5);
      else passes++;
   endtask

   task automatic test_reset_mid_run();
      a5 = 5'd9; b5 = 5'd11; sm5 = 1'b0; in_valid5 = 1'b1;
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (busy5 !== 1'b1) $display("FAIL midrun_busy: got %b required 1", busy5);
      else passes++;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (in_ready5 !== 1'b1 || busy5 !== 1'b0 || out_valid5 !== 1'b0 || p5 !== 10'd0)
         $display("FAIL midrun_reset: in_ready=%b busy=%b out_valid=%b product=%0d required 1 0 0 0",
                  in_ready5, busy5, out_valid5, p5);
      else passes++;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      do_op5(5'd3, 5'd5, 1'b0, 10'd15, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [4:0] ta [3];
      logic [4:0] tb [3];
      logic [9:0] te [3];
      logic [9:0] got [$];
      int idx;
      bit acc_now;
      ta = '{5'd6, 5'd0, 5'd1};
      tb = '{5'd7, 5'd31, 5'd1};
      te = '{10'd42, 10'd0, 10'd1};
      out_ready5 = 1'b1;
      idx = 0;
      a5 = ta[0]; b5 = tb[0]; sm5 = 1'b0; in_valid5 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         acc_now = in_valid5 && in_ready5;
         if (out_valid5 === 1'b1 && out_ready5) got.push_back(p5);
         @(posedge clk); #1;
         if (acc_now) begin
            idx++;
            if (idx < 3) begin a5 = ta[idx]; b5 = tb[idx]; end
            else in_valid5 = 1'b0;
         end
      end
      in_valid5 = 1'b0;
      checks++;
      if (idx !== 3) $display("FAIL b2b_accepts: got %0d required 3", idx);
      else passes++;
      checks++;
      if (got.size() !== 3) $display("FAIL b2b_count: got %0d required 3", got.size());
      else passes++;
      for (int i = 0; i < 3; i++) begin
         if (i < got.size()) begin
            $display("op b2b[%0d]: product=%0d", i, got[i]);
            checks++;
            if (got[i] !== te[i]) $display("FAIL b2b_result[%0d]: got %0d required %0d", i, got[i], te[i]);
            else passes++;
         end
      end
   endtask

   task automatic test_random(input int n, input int ops);
      longint expq [$];
      longint a, b, e, pr, mask;
      bit s, cur_valid, oready, ir, ov;
      int sent, recv, cyc;
      mask = (longint'(1) << n) - 1;
      sent = 0; recv = 0; cyc = 0; cur_valid = 0;
      a = 0; b = 0; s = 0;
      while (recv < ops && cyc < 30000) begin
         if (!cur_valid && sent < ops && $urandom_range(3) != 0) begin
            a = longint'($urandom) & mask;
            b = longint'($urandom) & mask;
            s = 1'($urandom);
            cur_valid = 1'b1;
         end
         oready = ($urandom_range(2) != 0);
         if (n == 5) begin
            in_valid5 = cur_valid; out_ready5 = oready;
            a5 = cur_valid ? a[4:0] : 5'($urandom);
            b5 = cur_valid ? b[4:0] : 5'($urandom);
            sm5 = cur_valid ? s : 1'($urandom);
            ir = in_ready5; ov = out_valid5; pr = longint'(p5);
         end else begin
            in_valid8 = cur_valid; out_ready8 = oready;
            a8 = cur_valid ? a[7:0] : 8'($urandom);
            b8 = cur_valid ? b[7:0] : 8'($urandom);
            sm8 = cur_valid ? s : 1'($urandom);
            ir = in_ready8; ov = out_valid8; pr = longint'(p8);
         end
         if (ov && oready) begin
            e = (expq.size() > 0) ? expq.pop_front() : -1;
            recv++;
            $display("rand N=%0d op %0d: product=0x%0h expected=0x%0h", n, recv, pr, e);
            checks++;
            if (pr !== e) $display("FAIL rand%0d op %0d: got 0x%0h required 0x%0h", n, recv, pr, e);
            else passes++;
         end
         if (cur_valid && ir) begin
            expq.push_back(ref_mul(a, b, s, n));
            sent++;
            cur_valid = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid5 = 1'b0; in_valid8 = 1'b0;
      checks++;
      if (recv !== ops) $display("FAIL rand%0d_count: got %0d results required %0d", n, recv, ops);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      test_random(5, 500);
      test_random(8, 500);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
